// File: rtl/dm_responder.sv
// Data-memory responder for the DM port: single-port word array with a one-entry
// write buffer, read-after-write byte forwarding and a post-reset clear sequencer.
module dm_responder #(
    parameter int ADDR_W   = 14,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CS,
    input  logic [3:0]        WEB,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic              READY
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_EN ? ST_CLEAR : ST_RUN;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;

    logic              wb_valid_reg;
    logic [ADDR_W-1:0] wb_addr_reg;
    logic [31:0]       wb_data_reg;
    logic [3:0]        wb_mask_reg;

    logic [3:0][7:0]   mem [DEPTH];

    logic              accept;
    logic              is_read;
    logic              is_write;
    logic              fwd_hit;
    logic [31:0]       rd_word;
    logic [31:0]       fwd_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;

    assign READY    = (state_reg == ST_RUN);
    assign accept   = CS & READY;
    assign is_write = accept & ~(&WEB);
    assign is_read  = accept & (&WEB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RESET_STATE;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            ST_CLEAR: begin
                clr_addr_next = clr_addr_reg + ADDR_W'(1);
                if (clr_addr_reg == {ADDR_W{1'b1}}) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    // Single write port shared by the clear sequencer and the write-buffer commit;
    // the buffer is never valid while clearing, so the two never collide.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wb_addr_reg;
        mem_wdata = wb_data_reg;
        mem_wmask = wb_mask_reg;
        if (state_reg == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_reg;
            mem_wdata = 32'h0;
            mem_wmask = 4'b1111;
        end else if (wb_valid_reg) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && mem_wmask[i]) begin
                mem[mem_waddr][i] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Forwarding: the pending buffer entry overrides the array on its enabled lanes.
    assign rd_word = mem[A];
    assign fwd_hit = wb_valid_reg && (wb_addr_reg == A);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fwd_lane
            assign fwd_word[8*gi +: 8] = (fwd_hit && wb_mask_reg[gi]) ?
                                         wb_data_reg[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
            wb_data_reg  <= 32'h0;
            wb_mask_reg  <= 4'b0000;
        end else begin
            wb_valid_reg <= is_write;
            if (is_write) begin
                wb_addr_reg <= A;
                wb_data_reg <= DI;
                wb_mask_reg <= ~WEB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DO <= 32'h0;
        end else if (is_read) begin
            DO <= fwd_word;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a memory model in which every accepted write is visible
// immediately, compared against the DUT on every falling edge, plus literal checks.
module tb_dm_responder;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          CS  = 1'b0;
    logic [3:0]    WEB = 4'hF;
    logic [AW-1:0] A   = '0;
    logic [31:0]   DI  = 32'h0;
    logic [31:0]   DO;
    logic          READY;

    logic          cs0 = 1'b0;
    logic [31:0]   DO0;
    logic          READY0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(AW), .CLEAR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .CS(CS), .WEB(WEB), .A(A), .DI(DI),
        .DO(DO), .READY(READY)
    );

    dm_responder #(.ADDR_W(AW), .CLEAR_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .CS(cs0), .WEB(WEB), .A(A), .DI(DI),
        .DO(DO0), .READY(READY0)
    );

    // Reference: memory reads as all-zero once clearing finishes; writes land at once.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_do;
    int          m_clr;

    function automatic logic [31:0] apply(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] web);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (!web[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_clr <= 0;
            m_do  <= 32'h0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'h0;
        end else if (m_clr < DEPTH) begin
            m_clr <= m_clr + 1;
        end else if (CS) begin
            if (WEB == 4'hF) m_do <= m_mem[A];
            else             m_mem[A] <= apply(m_mem[A], DI, WEB);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("DO", DO, m_do);
            chk("READY", {31'b0, READY}, {31'b0, (m_clr == DEPTH)});
            chk("DO0", DO0, 32'h0);
            chk("READY0", {31'b0, READY0}, 32'h1);
        end
    end

    task automatic op(input logic cs, input logic [3:0] web, input logic [AW-1:0] a,
                      input logic [31:0] di);
        CS  = cs;
        WEB = web;
        A   = a;
        DI  = di;
        @(posedge clk);
        #1;
        $display("txn cs=%0d web=%b a=%0d di=%h -> do=%h ready=%0d", cs, web, a, di, DO, READY);
    endtask

    // Counts not-ready cycles while hammering dropped writes at address 1.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (READY) begin
                CS = 1'b0;
                break;
            end
            n++;
            CS  = 1'b1;
            WEB = 4'b0000;
            A   = AW'(1);
            DI  = $urandom;
        end
        CS = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_ready(n);
        chk("clear_len", 32'(n), 32'd16);

        for (int a = 0; a < DEPTH; a++) begin
            op(1'b1, 4'hF, AW'(a), 32'h0);
            chk("clear_rd", DO, 32'h0);
        end

        op(1'b1, 4'b0000, 4'd3, 32'hDEADBEEF);
        op(1'b1, 4'hF, 4'd3, 32'h0);
        chk("fwd_full", DO, 32'hDEADBEEF);
        op(1'b0, 4'hF, 4'd0, 32'h0);
        op(1'b1, 4'hF, 4'd3, 32'h0);
        chk("array_full", DO, 32'hDEADBEEF);

        op(1'b1, 4'b0000, 4'd5, 32'h11223344);
        op(1'b0, 4'hF, 4'd0, 32'h0);
        op(1'b1, 4'b1101, 4'd5, 32'h0000AA00);
        op(1'b1, 4'hF, 4'd5, 32'h0);
        chk("fwd_byte", DO, 32'h1122AA44);

        op(1'b1, 4'b1110, 4'd7, 32'h000000FF);
        op(1'b1, 4'b1101, 4'd7, 32'h0000BB00);
        op(1'b1, 4'hF, 4'd7, 32'h0);
        chk("b2b_merge", DO, 32'h0000BBFF);

        op(1'b1, 4'b0000, 4'd7, 32'h12345678);
        op(1'b1, 4'hF, 4'd5, 32'h0);
        chk("other_addr", DO, 32'h1122AA44);
        op(1'b1, 4'hF, 4'd7, 32'h0);
        chk("after_other", DO, 32'h12345678);

        op(1'b1, 4'b1110, 4'd9, 32'h00000042);
        op(1'b1, 4'b0000, 4'd9, 32'h0);
        op(1'b0, 4'hF, 4'd0, 32'h0);
        chk("cs_low_hold", DO, 32'h12345678);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            op(($urandom_range(0, 9) < 8), w, AW'($urandom), $urandom);
        end

        op(1'b1, 4'b0000, 4'd2, 32'hCAFEF00D);
        op(1'b1, 4'hF, 4'd2, 32'h0);
        op(1'b1, 4'b0000, 4'd2, 32'hCAFEF00D);
        rst = 1'b0;
        #1;
        chk("do_in_reset", DO, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wait_ready(n);
        chk("clear_len2", 32'(n), 32'd16);
        op(1'b1, 4'hF, 4'd2, 32'h0);
        chk("rd_after_reset", DO, 32'h0);
        op(1'b1, 4'hF, 4'd1, 32'h0);
        chk("dropped_wr", DO, 32'h0);

        op(1'b0, 4'hF, 4'd0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
